cpu_regfile_sb: RTL

- 8-entry general-purpose register file with an integrated busy scoreboard, sitting directly upstream of the CPU's 8-way operand select mux.
- Supplies two read operands, accepts one write-back per cycle, and bypasses same-cycle write data to the readers.
- Tracks registers with pending multi-cycle results and raises `stall` when an issuing instruction depends on one.

---
 rtl/cpu_regfile_sb_pkg.sv | 18 +
 rtl/cpu_regfile_sb_if.sv | 33 +++
 rtl/regfile_sb_bit.sv | 28 ++
 rtl/cpu_regfile_sb.sv | 77 +++++++
 4 files changed

// File: rtl/cpu_regfile_sb_pkg.sv
// Shared CPU constants for the register file and scoreboard.
// Holds register-file sizing and the register-index names used by the decoder.
package cpu_regfile_sb_pkg;

  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = 3;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_R0 = 3'd0;
  localparam logic [REG_ADDR_W-1:0] REG_R1 = 3'd1;
  localparam logic [REG_ADDR_W-1:0] REG_R2 = 3'd2;
  localparam logic [REG_ADDR_W-1:0] REG_R3 = 3'd3;
  localparam logic [REG_ADDR_W-1:0] REG_R4 = 3'd4;
  localparam logic [REG_ADDR_W-1:0] REG_R5 = 3'd5;
  localparam logic [REG_ADDR_W-1:0] REG_R6 = 3'd6;
  localparam logic [REG_ADDR_W-1:0] REG_R7 = 3'd7;

endpackage

// File: rtl/cpu_regfile_sb_if.sv
// Operand/write-back/issue bundle between the pipeline and the register file.
// master: pipeline side (drives addresses, write-back, issue); slave: regfile.
interface cpu_regfile_sb_if #(
  parameter int BUSWIDTH = 32,
  parameter int SELWIDTH = 3
);

  logic [SELWIDTH-1:0]      rs1;
  logic [SELWIDTH-1:0]      rs2;
  logic [BUSWIDTH-1:0]      rdata1;
  logic [BUSWIDTH-1:0]      rdata2;
  logic                     wb_en;
  logic [SELWIDTH-1:0]      wb_addr;
  logic [BUSWIDTH-1:0]      wb_data;
  logic                     issue_valid;
  logic                     issue_rd_en;
  logic [SELWIDTH-1:0]      issue_rd;
  logic                     stall;
  logic [(1<<SELWIDTH)-1:0] busy;

  modport master (
    output rs1, rs2, wb_en, wb_addr, wb_data,
    output issue_valid, issue_rd_en, issue_rd,
    input  rdata1, rdata2, stall, busy
  );

  modport slave (
    input  rs1, rs2, wb_en, wb_addr, wb_data,
    input  issue_valid, issue_rd_en, issue_rd,
    output rdata1, rdata2, stall, busy
  );

endinterface

// File: rtl/regfile_sb_bit.sv
// One scoreboard bit: set marks a pending result, clr retires it.
// Ports: clk, reset_n (async low), set, clr, q. Set beats clr.
module regfile_sb_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  logic busy_d;
  logic busy_q;

  // A new owner issuing in the retire cycle keeps the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (clr) busy_d = 1'b0;
    if (set) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= 1'b0;
    else          busy_q <= busy_d;
  end

  assign q = busy_q;

endmodule

// File: rtl/cpu_regfile_sb.sv
// 8-entry register file with write-through bypass and busy scoreboard.
// Ports: clk, reset_n (async low), rf (slave: reads, write-back, issue/stall/busy).
module cpu_regfile_sb
  import cpu_regfile_sb_pkg::*;
#(
  parameter int BUSWIDTH = XLEN,
  parameter int SELWIDTH = REG_ADDR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_regfile_sb_if.slave  rf
);

  localparam int NREG = 1 << SELWIDTH;

  logic [BUSWIDTH-1:0] regs_d [NREG];
  logic [BUSWIDTH-1:0] regs_q [NREG];

  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] sb_set;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] eff_busy;
  logic            stall;
  logic            accept;
  logic [BUSWIDTH-1:0] rdata1;
  logic [BUSWIDTH-1:0] rdata2;

  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (rf.wb_en) regs_d[rf.wb_addr] = rf.wb_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Same-cycle write-back is forwarded to both readers.
  always_comb begin
    rdata1 = regs_q[rf.rs1];
    rdata2 = regs_q[rf.rs2];
    if (rf.wb_en && rf.wb_addr == rf.rs1) rdata1 = rf.wb_data;
    if (rf.wb_en && rf.wb_addr == rf.rs2) rdata2 = rf.wb_data;
  end

  // A write-back arriving now already resolves the hazard.
  assign eff_busy = busy & ~wb_hit;

  assign stall = rf.issue_valid &
                 (eff_busy[rf.rs1] | eff_busy[rf.rs2] |
                  (rf.issue_rd_en & eff_busy[rf.issue_rd]));

  assign accept = rf.issue_valid & ~stall;

  for (genvar g = 0; g < NREG; g++) begin : g_sb
    assign wb_hit[g] = rf.wb_en && (rf.wb_addr == SELWIDTH'(g));
    assign sb_set[g] = accept && rf.issue_rd_en &&
                       (rf.issue_rd == SELWIDTH'(g));

    regfile_sb_bit u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (sb_set[g]),
      .clr     (wb_hit[g]),
      .q       (busy[g])
    );
  end

  assign rf.rdata1 = rdata1;
  assign rf.rdata2 = rdata2;
  assign rf.stall  = stall;
  assign rf.busy   = busy;

endmodule
